// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction width, the NOP encoding used as the reset value of the
// instruction register, and small arithmetic helpers.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // Width of an instruction word.
  localparam int unsigned INST_W = 32;

  // Canonical NOP (addi x0, x0, 0) held in the instruction register after reset.
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_e;

  // A target is misaligned when it is not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_unit_detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// Rising-edge detector. Produces a one-cycle pulse in the cycle where d_i is
// high and was low in the previous cycle.
//
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset (history register cleared)
//   d_i      - level input to watch
//   pulse_o  - high for one cycle on each low-to-high transition of d_i
// -----------------------------------------------------------------------------
module detector_flanco (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic r_prev;

  // Remember the previous input level so a low-to-high transition can be seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= d_i;
    end
  end

  assign pulse_o = d_i & ~r_prev;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Holds the PC, issues word reads to instruction
// memory, registers the returned word and offers it to decode with a
// valid/ready handshake. Supports free-running and single-step operation,
// branch redirects without an extra bubble, and a sticky fault on a
// misaligned redirect target.
//
// Parameters:
//   RESET_PC      - PC loaded on reset
//   ADDR_W        - instruction-memory word-address width (PC bits [ADDR_W+1:2])
//
// Ports:
//   clk_i          - clock, all state changes on the rising edge
//   rst_i          - asynchronous active-high reset
//   run_i          - 1 = free-running fetch, 0 = single-step
//   step_i         - single-step request (rising edge only)
//   mem_req_o      - instruction-memory read request
//   mem_addr_o     - word address of the request (pc_o[ADDR_W+1:2])
//   mem_ack_i      - memory acknowledge, mem_rdata_i valid in that cycle
//   mem_rdata_i    - fetched instruction word
//   inst_valid_o   - inst_o/pc_o hold an instruction offered to decode
//   inst_ready_i   - decode accepts when inst_valid_o & inst_ready_i
//   inst_o         - registered instruction word
//   pc_o           - PC of the current instruction
//   pcplus4_o      - pc_o + 4 (wraps modulo 2^32)
//   redirect_i     - branch taken from execute (only sampled on an accept)
//   redirect_pc_i  - branch target
//   misalign_o     - sticky misaligned-target fault, cleared only by reset
//   fetch_count_o  - saturating count of accepted instructions
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              step_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pcplus4_o,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              misalign_o,
  output logic [31:0]       fetch_count_o
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_nxt;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_inst_nxt;
  logic              r_misalign;
  logic              w_misalign_nxt;
  logic [31:0]       r_fetch_count;
  logic [31:0]       w_fetch_count_nxt;
  logic              w_step_pulse;

  // Step edges are detected continuously; they only matter in IDLE, so an
  // edge seen in any other state is simply lost rather than queued.
  detector_flanco u_step_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (step_i),
    .pulse_o (w_step_pulse)
  );

  // Next-state and datapath update logic for the fetch FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_inst_nxt        = r_inst;
    w_misalign_nxt    = r_misalign;
    w_fetch_count_nxt = r_fetch_count;

    case (r_state)
      ST_IDLE: begin
        if (run_i || w_step_pulse) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Address is the PC itself, so it stays put until the ack arrives.
        if (mem_ack_i) begin
          w_inst_nxt  = mem_rdata_i;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end

      ST_HOLD: begin
        if (inst_ready_i) begin
          w_fetch_count_nxt = sat_inc32(r_fetch_count);
          if (redirect_i) begin
            if (is_misaligned(redirect_pc_i[1:0])) begin
              w_misalign_nxt = 1'b1;
              w_pc_nxt       = redirect_pc_i & ~32'h0000_0003;
              w_state_nxt    = ST_FAULT;
            end else begin
              // Loading the target here and going straight to REQ means a
              // taken branch costs nothing beyond the normal fetch latency.
              w_pc_nxt    = redirect_pc_i;
              w_state_nxt = run_i ? ST_REQ : ST_IDLE;
            end
          end else begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = run_i ? ST_REQ : ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end

      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_inst        <= NOP_INST;
      r_misalign    <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_inst        <= w_inst_nxt;
      r_misalign    <= w_misalign_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // Handshake outputs are pure decodes of the state register, so reset
  // drops them in the same cycle it is asserted.
  assign mem_req_o     = (r_state == ST_REQ);
  assign inst_valid_o  = (r_state == ST_HOLD);
  assign mem_addr_o    = r_pc[ADDR_W+1:2];
  assign inst_o        = r_inst;
  assign pc_o          = r_pc;
  assign pcplus4_o     = r_pc + 32'd4;
  assign misalign_o    = r_misalign;
  assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed self-checking bench for fetch_unit. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap and reset during a request.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rst_b;
  logic        run;
  logic        step;
  logic        ack;
  logic [31:0] rdata;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mem_salt;

  logic        req;
  logic [5:0]  addr;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic        misalign;
  logic [31:0] count;

  logic        b_req;
  logic [5:0]  b_addr;
  logic        b_valid;
  logic [31:0] b_inst;
  logic [31:0] b_pc;
  logic [31:0] b_pcp4;
  logic        b_misalign;
  logic [31:0] b_count;

  int n_tests;
  int n_fail;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step),
    .mem_req_o(req), .mem_addr_o(addr), .mem_ack_i(ack), .mem_rdata_i(rdata),
    .inst_valid_o(valid), .inst_ready_i(ready), .inst_o(inst), .pc_o(pc),
    .pcplus4_o(pcp4), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .misalign_o(misalign), .fetch_count_o(count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(6)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .run_i(run), .step_i(step),
    .mem_req_o(b_req), .mem_addr_o(b_addr), .mem_ack_i(ack), .mem_rdata_i(rdata),
    .inst_valid_o(b_valid), .inst_ready_i(ready), .inst_o(b_inst), .pc_o(b_pc),
    .pcplus4_o(b_pcp4), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .misalign_o(b_misalign), .fetch_count_o(b_count)
  );

  // Memory model: word content tagged with the address and a changeable salt.
  always_comb rdata = {mem_salt, 10'd0, addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; ack = 1'b0; ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; mem_salt = 16'hC0DE;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic found;
    logic [31:0] held_inst;
    n_tests = 0;
    n_fail  = 0;
    rst_b   = 1'b1;

    // Reset values
    do_reset();
    rst = 1'b1;
    #1;
    chk_val("rst_pc", pc, 32'h0);
    chk_val("rst_pcp4", pcp4, 32'h4);
    chk_val("rst_inst", inst, 32'h0000_0013);
    chk_val("rst_valid", {31'd0, valid}, 32'd0);
    chk_val("rst_req", {31'd0, req}, 32'd0);
    chk_val("rst_misalign", {31'd0, misalign}, 32'd0);
    chk_val("rst_count", count, 32'd0);
    rst = 1'b0;

    // Run mode: back-to-back fetches, one accept every 2 cycles
    run = 1'b1; ack = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_val("run_req", {31'd0, req}, 32'd1);
      chk_val("run_addr", {26'd0, addr}, i);
      tick();
      chk_val("run_valid", {31'd0, valid}, 32'd1);
      chk_val("run_pc", pc, 32'(4 * i));
      chk_val("run_inst", inst, 32'hC0DE_0000 + 32'(i));
      if (i == 3) run = 1'b0;
    end
    tick();
    chk_val("run_count", count, 32'd4);
    chk_val("run_pc_end", pc, 32'd16);
    chk_val("run_idle_req", {31'd0, req}, 32'd0);

    // Step mode: three long step pulses give exactly three accepts
    do_reset();
    ack = 1'b1; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      repeat (5) tick();
      step = 1'b0;
      repeat (3) tick();
      chk_val("step_count", count, 32'(k + 1));
    end
    chk_val("step_pc", pc, 32'd12);
    chk_val("step_idle_valid", {31'd0, valid}, 32'd0);
    chk_val("step_idle_req", {31'd0, req}, 32'd0);

    // Redirect at pc=0x10 to 0x40, no bubble
    do_reset();
    run = 1'b1; ack = 1'b1; ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid && pc == 32'h10) begin
        found = 1'b1;
        break;
      end
    end
    chk_val("redir_reach", {31'd0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk_val("redir_req", {31'd0, req}, 32'd1);
    chk_val("redir_addr", {26'd0, addr}, 32'h10);
    chk_val("redir_pc", pc, 32'h40);
    chk_val("redir_count", count, 32'd5);
    tick();
    // Redirect without an accept must be ignored
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    chk_val("redir_noacc_pc", pc, 32'h40);
    chk_val("redir_noacc_valid", {31'd0, valid}, 32'd1);

    // Misaligned redirect -> sticky fault
    ready = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    chk_val("mis_flag", {31'd0, misalign}, 32'd1);
    chk_val("mis_pc", pc, 32'h40);
    chk_val("mis_count", count, 32'd6);
    repeat (3) tick();
    chk_val("mis_noreq", {31'd0, req}, 32'd0);
    chk_val("mis_novalid", {31'd0, valid}, 32'd0);
    chk_val("mis_sticky", {31'd0, misalign}, 32'd1);
    rst = 1'b1;
    #1;
    chk_val("mis_rst_flag", {31'd0, misalign}, 32'd0);
    chk_val("mis_rst_pc", pc, 32'h0);
    tick();
    rst = 1'b0;

    // Delayed ack, ready held low, spurious ack in HOLD
    do_reset();
    run = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk_val("dly_req", {31'd0, req}, 32'd1);
      chk_val("dly_addr", {26'd0, addr}, 32'd0);
      tick();
    end
    chk_val("dly_req_last", {31'd0, req}, 32'd1);
    ack = 1'b1;
    tick();
    held_inst = 32'hC0DE_0000;
    chk_val("dly_inst", inst, held_inst);
    mem_salt = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_val("hold_valid", {31'd0, valid}, 32'd1);
      chk_val("hold_inst", inst, held_inst);
      chk_val("hold_addr", {26'd0, addr}, 32'd0);
      chk_val("hold_pc", pc, 32'd0);
    end
    run = 1'b0; ready = 1'b1;
    tick();
    chk_val("hold_acc_pc", pc, 32'd4);
    chk_val("hold_acc_count", count, 32'd1);

    // PC wrap and reset mid-REQ on the second instance
    do_reset();
    rst = 1'b1;
    rst_b = 1'b0;
    #1;
    chk_val("wrap_rst_pc", b_pc, 32'hFFFF_FFFC);
    chk_val("wrap_rst_pcp4", b_pcp4, 32'h0);
    chk_val("wrap_rst_addr", {26'd0, b_addr}, 32'h3F);
    run = 1'b1; ack = 1'b1; ready = 1'b1;
    tick();
    tick();
    chk_val("wrap_valid", {31'd0, b_valid}, 32'd1);
    run = 1'b0;
    tick();
    chk_val("wrap_pc", b_pc, 32'h0);
    chk_val("wrap_pcp4", b_pcp4, 32'h4);
    chk_val("wrap_misalign", {31'd0, b_misalign}, 32'd0);
    run = 1'b1; ack = 1'b0;
    tick();
    chk_val("midreq_req", {31'd0, b_req}, 32'd1);
    rst_b = 1'b1;
    #1;
    chk_val("midreq_rst_req", {31'd0, b_req}, 32'd0);
    ack = 1'b1; run = 1'b0;
    tick();
    rst_b = 1'b0;
    tick();
    chk_val("late_ack_req", {31'd0, b_req}, 32'd0);
    chk_val("late_ack_valid", {31'd0, b_valid}, 32'd0);
    chk_val("late_ack_inst", b_inst, 32'h0000_0013);
    chk_val("late_ack_count", b_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
